// File: rtl/writeback_queue_if.sv
// Result-handshake and register-file write-port bundle for writeback_queue.
// The slave side is the queue; the master side is the producers plus the write-port consumer.
interface writeback_queue_if #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_WIDTH = 32
);
  localparam int unsigned IW = $clog2(REG_COUNT);

  logic                 alu_valid;
  logic                 alu_ready;
  logic [IW-1:0]        alu_rd;
  logic [REG_WIDTH-1:0] alu_value;

  logic                 mem_valid;
  logic                 mem_ready;
  logic [IW-1:0]        mem_rd;
  logic [REG_WIDTH-1:0] mem_value;

  logic                 wb_stall;
  logic [IW-1:0]        rd;
  logic [REG_WIDTH-1:0] rd_value;
  logic                 wr_en;

  modport master (
    output alu_valid, alu_rd, alu_value,
    output mem_valid, mem_rd, mem_value,
    output wb_stall,
    input  alu_ready, mem_ready,
    input  rd, rd_value, wr_en
  );

  modport slave (
    input  alu_valid, alu_rd, alu_value,
    input  mem_valid, mem_rd, mem_value,
    input  wb_stall,
    output alu_ready, mem_ready,
    output rd, rd_value, wr_en
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order write-back FIFO with per-register pending tracking (load beats ALU on enqueue).
// Optional combinational forwarding lookup is built only when WB_FORWARD_EN is defined.
module writeback_queue #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  writeback_queue_if.slave             bus,
  input  logic [$clog2(REG_COUNT)-1:0] rs1,
  input  logic [$clog2(REG_COUNT)-1:0] rs2,
  output logic [REG_COUNT-1:0]         pending_mask,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         fwd1_hit,
  output logic [REG_WIDTH-1:0]         fwd1_value,
  output logic                         fwd2_hit,
  output logic [REG_WIDTH-1:0]         fwd2_value
);
  localparam int unsigned IW = $clog2(REG_COUNT);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [IW-1:0]        q_rd  [DEPTH];
  logic [REG_WIDTH-1:0] q_val [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        pend_cnt [REG_COUNT];

  logic                 pop;
  logic                 space;
  logic                 mem_fire;
  logic                 alu_fire;
  logic                 push;
  logic [IW-1:0]        in_rd;
  logic [REG_WIDTH-1:0] in_val;
  logic [REG_COUNT-1:0] inc;
  logic [REG_COUNT-1:0] dec;

  assign pop   = (level != '0) && !bus.wb_stall;
  assign space = (level < LW'(DEPTH)) || pop;

  // Readies are gated by reset_n so they stay low for the whole reset window.
  assign bus.mem_ready = reset_n && space;
  assign bus.alu_ready = reset_n && space && !bus.mem_valid;

  assign mem_fire = bus.mem_valid && bus.mem_ready;
  assign alu_fire = bus.alu_valid && bus.alu_ready;
  assign in_rd    = mem_fire ? bus.mem_rd    : bus.alu_rd;
  assign in_val   = mem_fire ? bus.mem_value : bus.alu_value;
  // Writes to r0 complete the handshake but never occupy a slot.
  assign push     = (mem_fire || alu_fire) && (in_rd != '0);

  assign bus.wr_en    = pop;
  assign bus.rd       = pop ? q_rd[head]  : '0;
  assign bus.rd_value = pop ? q_val[head] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]  <= in_rd;
      q_val[tail] <= in_val;
    end
  end

  always_comb begin
    inc = '0;
    dec = '0;
    if (push) inc[in_rd] = 1'b1;
    if (pop)  dec[q_rd[head]] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) pend_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        if (inc[i] && !dec[i])      pend_cnt[i] <= pend_cnt[i] + 1'b1;
        else if (dec[i] && !inc[i]) pend_cnt[i] <= pend_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 1; i < REG_COUNT; i++) pending_mask[i] = (pend_cnt[i] != '0);
  end

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the last match wins; level is 0 under reset.
  always_comb begin
    fwd1_hit   = 1'b0;
    fwd1_value = '0;
    fwd2_hit   = 1'b0;
    fwd2_value = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (LW'(k) < level) begin
        if ((rs1 != '0) && (q_rd[PW'(head + PW'(k))] == rs1)) begin
          fwd1_hit   = 1'b1;
          fwd1_value = q_val[PW'(head + PW'(k))];
        end
        if ((rs2 != '0) && (q_rd[PW'(head + PW'(k))] == rs2)) begin
          fwd2_hit   = 1'b1;
          fwd2_value = q_val[PW'(head + PW'(k))];
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1, rs2};
  assign fwd1_hit   = 1'b0;
  assign fwd1_value = '0;
  assign fwd2_hit   = 1'b0;
  assign fwd2_value = '0;
`endif
endmodule

// File: doc/writeback_queue.md
# writeback_queue

Write-side initiator for the processor's register file. Accepts completed results from the ALU and load/store unit over valid/ready handshakes and buffers them in a small in-order FIFO. Drains one entry per cycle onto the register file write port (`rd`, `rd_value`, `wr_en`). Publishes a per-register pending mask so issue logic can hold instructions whose source registers still have queued writes.

## Interface

Parameters:
- `REG_COUNT`, 32, number of architectural registers; register 0 is hardwired zero.
- `REG_WIDTH`, 32, data width of each register.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result valid.
- `alu_ready`  out  1  ALU result accepted this cycle when high together with `alu_valid`.
- `alu_rd`  in  $clog2(REG_COUNT)  ALU destination register.
- `alu_value`  in  REG_WIDTH  ALU result.
- `mem_valid`, `mem_ready`, `mem_rd`, `mem_value`  same directions and widths as the `alu_*` ports; load-unit result.
- `wb_stall`  in  1  write port is lent elsewhere this cycle; blocks the drain.
- `rd`  out  $clog2(REG_COUNT)  register file write index.
- `rd_value`  out  REG_WIDTH  register file write data.
- `wr_en`  out  1  register file write enable.
- `pending_mask`  out  REG_COUNT  bit i high while any queued entry targets register i.
- `level`  out  $clog2(DEPTH)+1  number of occupied entries.
- `rs1`, `rs2`  in  $clog2(REG_COUNT)  forwarding lookup indices.
- `fwd1_hit`, `fwd2_hit`  out  1  forwarding hit flags.
- `fwd1_value`, `fwd2_value`  out  REG_WIDTH  forwarded values.

## Operation

- FIFO uses a circular buffer. Head and tail pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. A separate count register drives `level`.
- Drain condition: `pop = (level != 0) && !wb_stall`. `wr_en = pop`. `rd` and `rd_value` come from the head entry. When `pop` is low, `rd` and `rd_value` are 0.
- Space: `space = (level < DEPTH) || pop`. Enqueue into a full FIFO is allowed in the same cycle as a pop.
- Arbitration is fixed priority, load before ALU, with at most one enqueue per cycle.
  - `mem_ready = space`.
  - `alu_ready = space && !mem_valid`.
- A handshake whose destination is register 0 completes normally but is discarded. It does not enqueue, does not change `level`, and does not set any pending bit.
- Pending tracking uses one counter per register, width `$clog2(DEPTH+1)`.
  - Increment on enqueue to that register; decrement on pop of an entry for that register.
  - Simultaneous increment and decrement of the same register: net count unchanged.
  - `pending_mask[i] = (count_i != 0)`. Bit 0 is always 0.
- Entries are written to the register file strictly in enqueue order. Two writes to the same register retire oldest first.
- Reset (asynchronous, any time, including mid-drain):
  - Pointers, `level`, and all pending counters go to 0.
  - `wr_en=0`, `rd=0`, `rd_value=0`, `pending_mask=0`, `alu_ready=0`, `mem_ready=0`, forwarding outputs 0.
  - Queued results are lost. The ready outputs stay low while `reset_n=0`.

## Timing

- Enqueue latency: a result handshaked at rising edge N appears on `wr_en`/`rd`/`rd_value` during cycle N+1 at the earliest, when the FIFO was empty and `wb_stall` is low. There is no combinational fall-through.
- The register file captures the write on the falling edge inside that cycle. Its read ports reflect the new value from mid-cycle N+1 onward.
- `pending_mask` and `level` are registered: they update at the edge that enqueues or pops.
- The `*_ready` outputs, `wr_en`, and the forwarding outputs are combinational from state plus `wb_stall`, `mem_valid`, `rs1` and `rs2`.
- Sustained throughput is one result per cycle when `wb_stall` is low.

## Configuration

- `WB_FORWARD_EN` defined:
  - `fwdN_hit` is high when any queued entry targets `rsN`, with `rsN != 0`.
  - `fwdN_value` is the youngest such entry's value. This includes the head entry being written this cycle.
  - The lookup is combinational.
- `WB_FORWARD_EN` undefined: all `fwd*` outputs are tied to 0 and no comparison logic is built. Issue logic must rely on `pending_mask` alone.

## Test plan

- Reset: `reset_n` low for 3 cycles with both sources valid → `alu_ready=mem_ready=0`, `wr_en=0`, `level=0`, `pending_mask=0`.
- Single write: ALU result rd=5, value 0xDEADBEEF, on an empty queue → `wr_en=1`, rd=5, `rd_value=0xDEADBEEF` the next cycle. `pending_mask[5]` is high for exactly that cycle.
- Simultaneous sources: mem rd=3 value 0x11 and ALU rd=4 value 0x22 in the same cycle → mem accepted first and ALU held (`alu_ready=0`). Writes retire as r3=0x11, then r4=0x22.
- Full and stall: `wb_stall=1` while 4 ALU results are enqueued → `level=4` and `alu_ready=0`. Release the stall with a 5th result valid → pop and enqueue occur in the same cycle and `level` stays 4.
- Register 0 and ordering: enqueue r0=0x55, then r7=0x1 and r7=0x2 → r0 is never written and `pending_mask[0]=0`. r7 is written 0x1 then 0x2, and `pending_mask[7]` clears after the second write.
- With `WB_FORWARD_EN`: stall and queue r9=0xA then r9=0xB, with rs1=9 → `fwd1_hit=1`, `fwd1_value=0xB`. Without the macro → `fwd1_hit=0`.
